mem_access_requester: RTL and testbench
=======================================

// Module: mem_access_requester
// PURPOSE
// - Initiator side of the cache/RAM memory system: sits in the pipeline MEM stage and turns load/store requests into memory system accesses.
// - Drives address, writedata and writeen to the memory system and watches hit; stalls the pipeline until hit; returns load data.
// - Bounds every miss with a timeout and keeps hit/miss statistics.
// PARAMETERS
// - ADDR_W      6   memory address width (must match the memory system)
// - DATA_W      8   data width
// - MISS_LIMIT  16  max cycles spent in MISS before the request is aborted with an error
// - CNT_W       16  width of the hit/miss statistic counters
// PORTS
// - clk         in   1       single clock, rising edge
// - reset       in   1       asynchronous, active-high; clears all state
// - req_valid   in   1       pipeline request; held stable while stall=1
// - req_write   in   1       1=store, 0=load
// - req_addr    in   ADDR_W  request address
// - req_wdata   in   DATA_W  store data
// - stall       out  1       freeze pipeline (combinational)
// - resp_valid  out  1       one-cycle completion pulse (registered)
// - resp_rdata  out  DATA_W  load data; 0 for stores and errors
// - resp_err    out  1       qualifies resp_valid: request timed out
// - mem_address out  ADDR_W  to memory system address
// - mem_wdata   out  DATA_W  to memory system writedata
// - mem_writeen out  1       to memory system writeen
// - mem_hit     in   1       from memory system hit
// - mem_rdata   in   DATA_W  from memory system readdata (0 while writeen=1)
// - hit_count   out  CNT_W   saturating count of first-cycle hits
// - miss_count  out  CNT_W   saturating count of requests that missed
// BEHAVIOUR
// - Reset: state=IDLE; all outputs 0, including mem_address, mem_wdata, mem_writeen, both counters, and the timeout counter.
// - FSM states: IDLE, ACCESS, MISS, RESP.
// - IDLE, req_valid=1: latch addr/wdata/write into registers and go to ACCESS. req_valid=0: stay.
// - ACCESS, mem_hit=1: capture mem_rdata (0 for a store), hit_count+1, go to RESP.
// - ACCESS, mem_hit=0: miss_count+1, clear the timeout counter, go to MISS.
// - MISS, mem_hit=1: capture mem_rdata and go to RESP.
// - MISS, no hit: the timeout counter increments each cycle. When it reaches MISS_LIMIT-1 with no hit, set the error flag and go to RESP.
// - RESP: resp_valid=1 for exactly one cycle, with resp_rdata/resp_err valid; then go to IDLE.
// - RESP -> next request: a new request is accepted only in IDLE, so back-to-back requests cost at least 1 idle cycle.
// - mem_address and mem_wdata come from the latched registers. They are held stable from ACCESS through RESP and keep their last value in IDLE.
// - mem_writeen = latched write AND state in {ACCESS, MISS}. It is 0 in IDLE and RESP; a store is therefore never re-issued after completion.
// - stall = (IDLE & req_valid) | ACCESS | MISS | RESP, so the pipeline advances on the cycle after the resp_valid pulse.
// - Latency: hit = request at cycle 0, ACCESS at cycle 1, resp_valid at cycle 2. Miss = resp_valid 1 cycle after hit is first seen in MISS.
// - Timeout: resp_err=1 and resp_rdata=0. The request is not retried; the error is not sticky. The stall releases normally after RESP.
// - Counters saturate at 2^CNT_W-1, with no wrap. A timed-out request counts only as a miss.
// - req_* changes while stall=1 are ignored; the latched copy is used.
// - Reset asserted mid-operation: immediate return to IDLE. mem_writeen drops asynchronously, and no resp_valid is produced for the aborted request.
// - mem_hit is sampled only in ACCESS and MISS; it is ignored in IDLE and RESP.
// STRUCTURE
// - Shared package (mem_pkg): ADDR_W, DATA_W, the state encoding localparams (IDLE=0, ACCESS=1, MISS=2, RESP=3), and the default MISS_LIMIT.
// - One sub-module: sat_counter (parameter CNT_W; ports clk, reset, inc, count), instantiated twice for hit_count and miss_count.
// - Top level holds the FSM, the request latch, the timeout counter and the response registers.
// TESTING
// - Load hit: req addr=0x05, mem_hit=1 in ACCESS, mem_rdata=0xA7 -> resp_valid at cycle 2, resp_rdata=0xA7, hit_count=1, stall high for cycles 0-2.
// - Load miss: mem_hit low for 3 MISS cycles, then high with 0x3C -> resp_rdata=0x3C, resp_err=0, miss_count=1, mem_address=0x05 stable throughout.
// - Store: write addr=0x2A, data=0x55, hit -> mem_writeen=1 only in ACCESS, resp_rdata=0x00, mem_writeen=0 in RESP and IDLE.
// - Timeout: mem_hit held 0 -> resp_valid with resp_err=1 after MISS_LIMIT MISS cycles, resp_rdata=0, then IDLE; the next hit request completes normally.
// - Reset mid-MISS: assert reset during MISS -> stall, mem_writeen and resp_valid are 0 immediately; counters read 0 after release.
// - Saturation, with CNT_W=2: 5 hit requests -> hit_count=3; req_addr changed during stall -> mem_address unchanged.

Source files
------------

// File: rtl/mem_pkg.sv
// mem_pkg: shared widths, default miss timeout and FSM state encoding for the memory requester.
package mem_pkg;
   localparam int ADDR_W     = 6;
   localparam int DATA_W     = 8;
   localparam int MISS_LIMIT = 16;
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      MISS   = 2'd2,
      RESP   = 2'd3
   } state_t;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: event counter that sticks at its maximum value instead of wrapping.
// Ports: clk, reset (async, active-high), inc (count this cycle), count (current value).
module sat_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);
   always_ff @(posedge clk or posedge reset)
      if (reset) count <= '0;
      else if (inc && count != '1) count <= count + CNT_W'(1);
endmodule

// File: rtl/mem_access_requester.sv
// mem_access_requester: MEM-stage initiator that issues one load/store to the memory system, stalls until hit or timeout, and counts hits/misses.
// Ports: clk, reset (async, active-high); req_valid/req_write/req_addr/req_wdata pipeline request;
//        stall, resp_valid/resp_rdata/resp_err pipeline response; mem_address/mem_wdata/mem_writeen/mem_hit/mem_rdata
//        memory system side; hit_count/miss_count saturating statistics.
module mem_access_requester #(
   parameter int ADDR_W     = mem_pkg::ADDR_W,
   parameter int DATA_W     = mem_pkg::DATA_W,
   parameter int MISS_LIMIT = mem_pkg::MISS_LIMIT,
   parameter int CNT_W      = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   input  logic              req_write,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              stall,
   output logic              resp_valid,
   output logic [DATA_W-1:0] resp_rdata,
   output logic              resp_err,
   output logic [ADDR_W-1:0] mem_address,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_writeen,
   input  logic              mem_hit,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [CNT_W-1:0]  hit_count,
   output logic [CNT_W-1:0]  miss_count
);
   import mem_pkg::*;

   localparam int TW = $clog2(MISS_LIMIT) + 1;

   state_t      state, nxt;
   logic        wr_q;
   logic [TW-1:0] tmr;
   logic        busy, accept, timeout;

   assign busy    = (state == ACCESS) || (state == MISS);
   assign accept  = (state == IDLE) && req_valid;
   // the last allowed MISS cycle without a hit ends the request with an error
   assign timeout = (state == MISS) && !mem_hit && (tmr == TW'(MISS_LIMIT - 1));

   always_comb begin
      nxt = state;
      case (state)
         IDLE:    nxt = req_valid ? ACCESS : IDLE;
         ACCESS:  nxt = mem_hit ? RESP : MISS;
         MISS:    nxt = (mem_hit || timeout) ? RESP : MISS;
         default: nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state       <= IDLE;
         mem_address <= '0;
         mem_wdata   <= '0;
         wr_q        <= 1'b0;
         tmr         <= '0;
         resp_rdata  <= '0;
         resp_err    <= 1'b0;
      end else begin
         state <= nxt;
         if (accept) begin
            mem_address <= req_addr;
            mem_wdata   <= req_wdata;
            wr_q        <= req_write;
         end
         if (state == ACCESS) tmr <= '0;
         else if (state == MISS && !mem_hit) tmr <= tmr + TW'(1);
         if (busy && mem_hit) begin
            resp_rdata <= wr_q ? '0 : mem_rdata;
            resp_err   <= 1'b0;
         end else if (timeout) begin
            resp_rdata <= '0;
            resp_err   <= 1'b1;
         end
      end

   // decoded from the state register, so reset drops these asynchronously
   assign resp_valid  = (state == RESP);
   assign mem_writeen = wr_q && busy;
   assign stall       = accept || (state != IDLE);

   sat_counter #(.CNT_W(CNT_W)) u_hit (
      .clk(clk), .reset(reset), .inc((state == ACCESS) && mem_hit), .count(hit_count)
   );
   sat_counter #(.CNT_W(CNT_W)) u_miss (
      .clk(clk), .reset(reset), .inc((state == ACCESS) && !mem_hit), .count(miss_count)
   );
endmodule

// File: tb/tb_mem_access_requester.sv
// tb_mem_access_requester: scoreboard bench for mem_access_requester with a scripted memory model.
module tb_mem_access_requester;
   localparam int AW = 6;
   localparam int DW = 8;
   localparam int ML = 16;
   localparam int CW = 2;
   localparam logic [CW-1:0] CMAX = '1;

   logic          clk = 0, reset = 1;
   logic          req_valid = 0, req_write = 0;
   logic [AW-1:0] req_addr = 0;
   logic [DW-1:0] req_wdata = 0;
   logic          stall, resp_valid, resp_err, mem_writeen;
   logic [DW-1:0] resp_rdata, mem_wdata;
   logic [AW-1:0] mem_address;
   logic          mem_hit = 0;
   logic [DW-1:0] mem_rdata = 0;
   logic [CW-1:0] hit_count, miss_count;

   typedef struct {
      logic [DW-1:0] rdata;
      logic          err;
      int            lat;
   } exp_t;

   exp_t sb[$];
   int n_tests = 0, n_fail = 0;
   logic [CW-1:0] exp_hit = 0, exp_miss = 0;

   mem_access_requester #(.ADDR_W(AW), .DATA_W(DW), .MISS_LIMIT(ML), .CNT_W(CW)) dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata), .stall(stall), .resp_valid(resp_valid),
      .resp_rdata(resp_rdata), .resp_err(resp_err), .mem_address(mem_address),
      .mem_wdata(mem_wdata), .mem_writeen(mem_writeen), .mem_hit(mem_hit),
      .mem_rdata(mem_rdata), .hit_count(hit_count), .miss_count(miss_count)
   );

   always #5 clk = ~clk;

   // nmiss = number of no-hit cycles (ACCESS included) before the memory hits
   task automatic run_req(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input int nmiss, input logic [DW-1:0] rd, input bit chg);
      exp_t e, g;
      bit done;
      e.err   = nmiss > ML;
      e.rdata = (w || e.err) ? '0 : rd;
      e.lat   = e.err ? ML + 2 : nmiss + 2;
      sb.push_back(e);
      if (nmiss == 0) begin if (exp_hit != CMAX) exp_hit++; end
      else if (exp_miss != CMAX) exp_miss++;
      @(negedge clk);
      req_valid = 1; req_write = w; req_addr = a; req_wdata = d; mem_hit = 0;
      #1;
      n_tests++;
      if (stall !== 1'b1) begin n_fail++; $display("FAIL stall_req: got %b expected 1", stall); end
      done = 0;
      for (int k = 1; k <= 40 && !done; k++) begin
         @(negedge clk);
         if (chg && k == 1) begin req_addr = ~a; req_wdata = ~d; req_write = ~w; end
         n_tests++;
         if (stall !== 1'b1 || mem_address !== a || mem_wdata !== d) begin
            n_fail++;
            $display("FAIL hold k=%0d: stall=%b addr=%h wdata=%h expected 1 %h %h", k, stall, mem_address, mem_wdata, a, d);
         end
         if (resp_valid === 1'b1) begin
            done = 1;
            req_valid = 0;
            n_tests++;
            if (sb.size() == 0) begin n_fail++; $display("FAIL sb_empty: got response with no expectation"); end
            else begin
               g = sb.pop_front();
               if (k != g.lat || resp_rdata !== g.rdata || resp_err !== g.err || mem_writeen !== 1'b0) begin
                  n_fail++;
                  $display("FAIL resp: lat=%0d rdata=%h err=%b we=%b expected %0d %h %b 0", k, resp_rdata, resp_err, mem_writeen, g.lat, g.rdata, g.err);
               end
            end
         end else begin
            n_tests++;
            if (mem_writeen !== w) begin n_fail++; $display("FAIL writeen k=%0d: got %b expected %b", k, mem_writeen, w); end
         end
         mem_hit   = (k - 1 >= nmiss);
         mem_rdata = mem_hit ? (w ? 8'hFF : rd) : 8'h00;
      end
      if (!done) begin n_tests++; n_fail++; req_valid = 0; $display("FAIL resp_timeout: no resp_valid within 40 cycles"); end
      @(negedge clk);
      mem_hit = 0;
      n_tests++;
      if (stall !== 1'b0 || mem_writeen !== 1'b0 || resp_valid !== 1'b0 || mem_address !== a) begin
         n_fail++;
         $display("FAIL idle: stall=%b we=%b rv=%b addr=%h expected 0 0 0 %h", stall, mem_writeen, resp_valid, mem_address, a);
      end
      n_tests++;
      if (hit_count !== exp_hit || miss_count !== exp_miss) begin
         n_fail++;
         $display("FAIL counters: hit=%0d miss=%0d expected %0d %0d", hit_count, miss_count, exp_hit, exp_miss);
      end
   endtask

   task automatic test_reset();
      reset = 1;
      repeat (2) @(negedge clk);
      n_tests++;
      if (stall !== 0 || resp_valid !== 0 || resp_rdata !== 0 || resp_err !== 0 || mem_address !== 0 ||
          mem_wdata !== 0 || mem_writeen !== 0 || hit_count !== 0 || miss_count !== 0) begin
         n_fail++;
         $display("FAIL reset: stall=%b rv=%b rd=%h err=%b addr=%h wd=%h we=%b hc=%0d mc=%0d expected all 0",
                  stall, resp_valid, resp_rdata, resp_err, mem_address, mem_wdata, mem_writeen, hit_count, miss_count);
      end
      reset = 0;
   endtask

   task automatic test_load_hit();   run_req(0, 6'h05, 8'h00, 0, 8'hA7, 0); endtask
   task automatic test_load_miss();  run_req(0, 6'h05, 8'h00, 4, 8'h3C, 0); endtask
   task automatic test_store();      run_req(1, 6'h2A, 8'h55, 0, 8'h00, 0); endtask

   task automatic test_timeout();
      run_req(0, 6'h11, 8'h00, 100, 8'h77, 0);
      run_req(0, 6'h12, 8'h00, 0, 8'h99, 0);
   endtask

   task automatic test_reset_mid_miss();
      @(negedge clk);
      req_valid = 1; req_write = 1; req_addr = 6'h15; req_wdata = 8'h33; mem_hit = 0;
      repeat (3) @(negedge clk);
      n_tests++;
      if (mem_writeen !== 1'b1) begin n_fail++; $display("FAIL pre_reset_we: got %b expected 1", mem_writeen); end
      #2 reset = 1; req_valid = 0;
      #1;
      n_tests++;
      if (stall !== 0 || mem_writeen !== 0 || resp_valid !== 0) begin
         n_fail++;
         $display("FAIL async_reset: stall=%b we=%b rv=%b expected 0 0 0", stall, mem_writeen, resp_valid);
      end
      @(negedge clk);
      reset = 0; exp_hit = 0; exp_miss = 0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         n_tests++;
         if (resp_valid !== 0 || hit_count !== 0 || miss_count !== 0 || mem_address !== 0) begin
            n_fail++;
            $display("FAIL post_reset: rv=%b hc=%0d mc=%0d addr=%h expected 0 0 0 0", resp_valid, hit_count, miss_count, mem_address);
         end
      end
   endtask

   task automatic test_saturation();
      for (int i = 0; i < 5; i++) run_req(0, 6'(8 + i), 8'h00, 0, 8'(8'h40 + i), i == 2);
      n_tests++;
      if (hit_count !== 2'd3) begin n_fail++; $display("FAIL hit_saturate: got %0d expected 3", hit_count); end
   endtask

   initial begin
      test_reset();
      test_load_hit();
      test_load_miss();
      test_store();
      test_timeout();
      test_reset_mid_miss();
      test_saturation();
      n_tests++;
      if (sb.size() != 0) begin n_fail++; $display("FAIL sb_leftover: got %0d expected 0", sb.size()); end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
